clock_divider_multi: RTL and testbench

Multi-channel programmable clock divider / tick generator; parametrised successor of the single fixed-limit wrap counter. NUM_CH independent channels, each with a runtime-writable WIDTH-bit divisor and a per-channel mode: single-cycle tick or 50% square-wave output. Sits between the board clock and slow consumers (LED blink, debounce sampling, display scan), replacing hard-coded per-use counters.

---
 rtl/clock_divider_multi.sv | 112 +++++++++++
 tb/tb_clock_divider_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider / tick generator with per-channel tick or square-wave mode.
// Define PRESCALER_EN to add a shared prescaler that gates all channels to its wrap strobe.
module clock_divider_multi #(
    parameter int WIDTH       = 32,
    parameter int NUM_CH      = 4,
    parameter int CH_BITS     = 2,
    parameter int DEFAULT_DIV = 200
`ifdef PRESCALER_EN
    ,
    parameter int PRESCALE    = 10
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_CH-1:0]  ch_enable,
    input  logic               wr_en,
    input  logic [CH_BITS-1:0] wr_ch,
    input  logic [WIDTH-1:0]   wr_div,
    input  logic               wr_mode,
    output logic [NUM_CH-1:0]  tick,
    output logic [NUM_CH-1:0]  clk_out
);

    logic [WIDTH-1:0]  cnt_r      [NUM_CH];
    logic [WIDTH-1:0]  div_r      [NUM_CH];
    logic [NUM_CH-1:0] mode_r;
    logic [NUM_CH-1:0] tick_r;
    logic [NUM_CH-1:0] clk_out_r;

    logic [WIDTH-1:0]  cnt_nxt_s  [NUM_CH];
    logic [WIDTH-1:0]  div_nxt_s  [NUM_CH];
    logic [NUM_CH-1:0] mode_nxt_s;
    logic [NUM_CH-1:0] tick_nxt_s;
    logic [NUM_CH-1:0] clk_out_nxt_s;
    logic              strobe_s;

`ifdef PRESCALER_EN
    logic [WIDTH-1:0]  pre_cnt_r;
    logic              pre_wrap_s;

    assign pre_wrap_s = (pre_cnt_r >= WIDTH'(PRESCALE));
    assign strobe_s   = enable & pre_wrap_s;

    // Shared prescaler counter, advancing on every enabled cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_cnt_r <= {WIDTH{1'b0}};
        end else if (enable) begin
            if (pre_wrap_s) begin
                pre_cnt_r <= {WIDTH{1'b0}};
            end else begin
                pre_cnt_r <= pre_cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    assign strobe_s = enable;
`endif

    // Per-channel next state: a configuration write overrides any wrap on the same edge
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt_s[i]     = cnt_r[i];
            div_nxt_s[i]     = div_r[i];
            mode_nxt_s[i]    = mode_r[i];
            tick_nxt_s[i]    = 1'b0;
            clk_out_nxt_s[i] = clk_out_r[i];
            if (wr_en && (wr_ch == CH_BITS'(i))) begin
                cnt_nxt_s[i]     = {WIDTH{1'b0}};
                div_nxt_s[i]     = wr_div;
                mode_nxt_s[i]    = wr_mode;
                clk_out_nxt_s[i] = 1'b0;
            end else if (strobe_s && ch_enable[i]) begin
                if (cnt_r[i] >= div_r[i]) begin
                    cnt_nxt_s[i]     = {WIDTH{1'b0}};
                    tick_nxt_s[i]    = 1'b1;
                    clk_out_nxt_s[i] = mode_r[i] ? ~clk_out_r[i] : 1'b0;
                end else begin
                    cnt_nxt_s[i]     = cnt_r[i] + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end else begin
                tick_nxt_s[i] = 1'b0;
            end
        end
    end

    // Channel state and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= {WIDTH{1'b0}};
                div_r[i] <= WIDTH'(DEFAULT_DIV);
            end
            mode_r    <= {NUM_CH{1'b0}};
            tick_r    <= {NUM_CH{1'b0}};
            clk_out_r <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
                div_r[i] <= div_nxt_s[i];
            end
            mode_r    <= mode_nxt_s;
            tick_r    <= tick_nxt_s;
            clk_out_r <= clk_out_nxt_s;
        end
    end

    assign tick    = tick_r;
    assign clk_out = clk_out_r;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: a 4-channel and a 3-channel instance share stimulus,
// and an arithmetic reference model (active-edge counts since last load) predicts every output.
module tb_clock_divider_multi;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        enable    = 1'b0;
    logic [3:0]  ch_enable = 4'b0000;
    logic        wr_en     = 1'b0;
    logic [1:0]  wr_ch     = 2'd0;
    logic [31:0] wr_div    = 32'd0;
    logic        wr_mode   = 1'b0;
    logic [3:0]  tick4, clk4;
    logic [2:0]  tick3, clk3;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;

    typedef struct packed {
        logic [3:0] t4;
        logic [3:0] c4;
        logic [2:0] t3;
        logic [2:0] c3;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;

    // Reference model state: [instance][channel]
    longint unsigned mk   [2][4];
    longint unsigned mdiv [2][4];
    bit              mmode[2][4];
    logic [3:0]      et   [2];
    logic [3:0]      ec   [2];

    clock_divider_multi dut4 (
        .clock(clock), .reset(reset), .enable(enable), .ch_enable(ch_enable),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .wr_mode(wr_mode),
        .tick(tick4), .clk_out(clk4)
    );

    clock_divider_multi #(.WIDTH(32), .NUM_CH(3), .CH_BITS(2), .DEFAULT_DIV(200)) dut3 (
        .clock(clock), .reset(reset), .enable(enable), .ch_enable(ch_enable[2:0]),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .wr_mode(wr_mode),
        .tick(tick3), .clk_out(clk3)
    );

    initial forever #5 clock = ~clock;

    // Predict the outputs after the coming edge from the inputs currently applied
    task automatic model_step();
        exp_t e;
        for (int m = 0; m < 2; m++) begin
            int nch;
            nch = (m == 0) ? 4 : 3;
            for (int c = 0; c < 4; c++) begin
                if (c >= nch) begin
                    et[m][c] = 1'b0;
                    ec[m][c] = 1'b0;
                end else if (reset) begin
                    mk[m][c] = 0; mdiv[m][c] = 200; mmode[m][c] = 1'b0;
                    et[m][c] = 1'b0; ec[m][c] = 1'b0;
                end else if (wr_en && int'(wr_ch) == c) begin
                    mk[m][c] = 0; mdiv[m][c] = longint'(wr_div); mmode[m][c] = wr_mode;
                    et[m][c] = 1'b0; ec[m][c] = 1'b0;
                end else if (enable && ch_enable[c]) begin
                    mk[m][c] = mk[m][c] + 1;
                    et[m][c] = ((mk[m][c] % (mdiv[m][c] + 1)) == 0);
                    ec[m][c] = mmode[m][c] && (((mk[m][c] / (mdiv[m][c] + 1)) % 2) == 1);
                end else begin
                    et[m][c] = 1'b0;
                end
            end
        end
        e.t4 = et[0];
        e.c4 = ec[0];
        e.t3 = et[1][2:0];
        e.c3 = ec[1][2:0];
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input int ch, input int d, input bit md);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_div = 32'(d); wr_mode = md;
        cycle();
        wr_en = 1'b0;
    endtask

    // Monitor: pop one expectation per edge and compare both instances
    always @(posedge clock) begin
        if (mon_on) begin
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard_empty @%0t: got no expectation, required one", $time);
            end else begin
                mon_e = exp_q.pop_front();
                n_cmp++;
                if (tick4 !== mon_e.t4 || clk4 !== mon_e.c4) begin
                    n_bad++;
                    $display("FAIL dut4_out @%0t: tick=%b clk_out=%b, required tick=%b clk_out=%b",
                             $time, tick4, clk4, mon_e.t4, mon_e.c4);
                end
                n_cmp++;
                if (tick3 !== mon_e.t3 || clk3 !== mon_e.c3) begin
                    n_bad++;
                    $display("FAIL dut3_out @%0t: tick=%b clk_out=%b, required tick=%b clk_out=%b",
                             $time, tick3, clk3, mon_e.t3, mon_e.c3);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        @(negedge clock);
        mon_on = 1'b1;
        run(3);

        // Default divisor on channel 0
        reset = 1'b0; enable = 1'b1; ch_enable = 4'b0001;
        run(420);

        // Square mode, div 3
        wr(1, 3, 1'b1);
        ch_enable = 4'b0010;
        run(40);

        // div 0 tick every cycle; write to channel 3 (ignored by the 3-channel build)
        ch_enable = 4'b0111;
        wr(2, 0, 1'b0);
        run(10);
        wr(3, 7, 1'b1);
        run(20);

        // Write landing exactly on a channel-0 wrap edge
        guard = 0;
        while ((mk[0][0] % (mdiv[0][0] + 1)) != mdiv[0][0] && guard < 300) begin
            cycle();
            guard++;
        end
        wr(0, 5, 1'b0);
        run(9);

        // Pause channel 0 mid-count
        ch_enable[0] = 1'b0;
        run(10);
        ch_enable[0] = 1'b1;
        run(20);

        // Asynchronous reset while ticks and square outputs are high
        ch_enable = 4'b1111;
        wr(1, 0, 1'b1);
        run(3);
        model_step();
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (tick4 !== 4'b0000 || clk4 !== 4'b0000 || tick3 !== 3'b000 || clk3 !== 3'b000) begin
            n_bad++;
            $display("FAIL async_reset @%0t: tick4=%b clk4=%b tick3=%b clk3=%b, required all zero",
                     $time, tick4, clk4, tick3, clk3);
        end
        @(negedge clock);
        run(2);
        reset = 1'b0;
        run(410);

        // Randomized traffic
        repeat (3000) begin
            enable    = ($urandom_range(0, 9) != 0);
            ch_enable = 4'($urandom);
            wr_en     = ($urandom_range(0, 15) == 0);
            wr_ch     = 2'($urandom);
            wr_div    = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom_range(0, 6));
            wr_mode   = 1'($urandom);
            cycle();
        end
        wr_en = 1'b0;
        run(5);

        mon_on = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
